pt2262_frame_seq: RTL and testbench

- Sequences complete PT2262-style encoder frames: TRITS code-bit trits, then one sync bit, repeated REPEATS times.
- Accepts a packed trit word through a valid/ready handshake and emits the serial on/off keying waveform on q, one sample per clk (1 clk = 1 alpha).
- Sits between the UART command decoder and the RF transmitter pin, and replaces free-running per-bit generation with a framed, countable transmission.

---
 rtl/pt2262_frame_seq.sv | 158 +++++++++++++++
 tb/tb_pt2262_frame_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pt2262_frame_seq.sv
// rtl/pt2262_frame_seq.sv - PT2262-style framed encoder: TRITS code trits plus sync, repeated REPEATS times
module pt2262_frame_seq #(
    parameter int TRITS   = 12,
    parameter int REPEATS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*TRITS-1:0] frame_data,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic               abort,
    output logic               q,
    output logic               busy,
    output logic               frame_done,
    output logic               tx_done,
    output logic               code_err
);

    localparam int TIW = (TRITS > 1) ? $clog2(TRITS) : 1;
    localparam int RW  = $clog2(REPEATS) + 1;

    if (REPEATS < 1) begin : g_bad_repeats
        $error("pt2262_frame_seq: REPEATS must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, TRIT, SYNC} state_t;

    state_t             state;
    logic [2*TRITS-1:0] hold;
    logic [4:0]         trit_cnt;
    logic [6:0]         sync_cnt;
    logic [TIW-1:0]     trit_idx;
    logic [RW-1:0]      rep_cnt;
    logic               illegal;

    // Each trit is two 16-sample halves; a half is either 4H12L (short) or 12H4L (long).
    function automatic logic trit_wave(input logic [1:0] code, input logic [4:0] s);
        logic short_h;
        logic long_h;
        short_h = (s[3:0] < 4'd4);
        long_h  = (s[3:0] < 4'd12);
        case (code)
            2'b00:   return short_h;
            2'b01:   return long_h;
            2'b10:   return s[4] ? long_h : short_h;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] code_at(input logic [2*TRITS-1:0] w, input logic [TIW-1:0] idx);
        return w[2*int'(idx) +: 2];
    endfunction

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < TRITS; i++) begin
            if (frame_data[2*i +: 2] == 2'b11) illegal = 1'b1;
        end
    end

    assign busy        = (state != IDLE);
    assign frame_ready = (state == IDLE);

    // q is registered from the sample that the next state/counter values select,
    // so sample 0 of trit 0 appears in the first cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            trit_cnt   <= '0;
            sync_cnt   <= '0;
            trit_idx   <= '0;
            rep_cnt    <= '0;
            q          <= 1'b0;
            frame_done <= 1'b0;
            tx_done    <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            tx_done    <= 1'b0;
            code_err   <= 1'b0;
            case (state)
                IDLE: begin
                    q <= 1'b0;
                    if (frame_valid && !abort) begin
                        if (illegal) begin
                            code_err <= 1'b1;
                        end else begin
                            hold     <= frame_data;
                            state    <= TRIT;
                            trit_cnt <= '0;
                            sync_cnt <= '0;
                            trit_idx <= '0;
                            rep_cnt  <= '0;
                            q        <= trit_wave(frame_data[1:0], 5'd0);
                        end
                    end
                end
                TRIT: begin
                    if (abort) begin
                        state    <= IDLE;
                        q        <= 1'b0;
                        trit_cnt <= '0;
                        trit_idx <= '0;
                        rep_cnt  <= '0;
                    end else if (trit_cnt == 5'd31) begin
                        trit_cnt <= '0;
                        if (trit_idx == TIW'(TRITS - 1)) begin
                            state    <= SYNC;
                            sync_cnt <= '0;
                            trit_idx <= '0;
                            q        <= 1'b1;
                        end else begin
                            trit_idx <= trit_idx + TIW'(1);
                            q        <= trit_wave(code_at(hold, trit_idx + TIW'(1)), 5'd0);
                        end
                    end else begin
                        trit_cnt <= trit_cnt + 5'd1;
                        q        <= trit_wave(code_at(hold, trit_idx), trit_cnt + 5'd1);
                    end
                end
                SYNC: begin
                    if (abort) begin
                        state    <= IDLE;
                        q        <= 1'b0;
                        sync_cnt <= '0;
                        rep_cnt  <= '0;
                    end else if (sync_cnt == 7'd127) begin
                        sync_cnt <= '0;
                        if (rep_cnt == RW'(REPEATS - 1)) begin
                            state   <= IDLE;
                            rep_cnt <= '0;
                            q       <= 1'b0;
                        end else begin
                            state    <= TRIT;
                            trit_cnt <= '0;
                            trit_idx <= '0;
                            rep_cnt  <= rep_cnt + RW'(1);
                            q        <= trit_wave(hold[1:0], 5'd0);
                        end
                    end else begin
                        sync_cnt <= sync_cnt + 7'd1;
                        q        <= (sync_cnt < 7'd3);
                        if (sync_cnt == 7'd126) begin
                            frame_done <= 1'b1;
                            tx_done    <= (rep_cnt == RW'(REPEATS - 1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pt2262_frame_seq.sv
// tb/tb_pt2262_frame_seq.sv - self-checking bench for pt2262_frame_seq (REPEATS=1 and REPEATS=4 instances)
module tb_pt2262_frame_seq;

    localparam int TRITS = 12;
    localparam int FLEN  = TRITS * 32 + 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] fdata [2];
    logic        fv    [2];
    logic        ab    [2];
    logic        q     [2];
    logic        busy  [2];
    logic        ready [2];
    logic        fdone [2];
    logic        txd   [2];
    logic        cerr  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pt2262_frame_seq #(.TRITS(TRITS), .REPEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_data(fdata[0]), .frame_valid(fv[0]),
        .frame_ready(ready[0]), .abort(ab[0]), .q(q[0]), .busy(busy[0]),
        .frame_done(fdone[0]), .tx_done(txd[0]), .code_err(cerr[0])
    );

    pt2262_frame_seq #(.TRITS(TRITS), .REPEATS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .frame_data(fdata[1]), .frame_valid(fv[1]),
        .frame_ready(ready[1]), .abort(ab[1]), .q(q[1]), .busy(busy[1]),
        .frame_done(fdone[1]), .tx_done(txd[1]), .code_err(cerr[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Waveform rule: alternating H/L segment lengths per code, sync = 4H then L.
    function automatic logic exp_q(input logic [23:0] w, input int t);
        int pos, tr, s, acc, code;
        int seg [4];
        pos = t % FLEN;
        if (pos >= TRITS * 32) return ((pos - TRITS * 32) < 4);
        tr   = pos / 32;
        s    = pos % 32;
        code = (w >> (2 * tr)) & 3;
        case (code)
            0:       seg = '{4, 12, 4, 12};
            1:       seg = '{12, 4, 12, 4};
            default: seg = '{4, 12, 12, 4};
        endcase
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (s < acc + seg[k]) return (k % 2 == 0);
            acc += seg[k];
        end
        return 1'b0;
    endfunction

    function automatic logic has_illegal(input logic [23:0] w);
        for (int i = 0; i < TRITS; i++) if (((w >> (2 * i)) & 24'h3) == 24'h3) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int total_len(input int k);
        return (k == 0 ? 1 : 4) * FLEN;
    endfunction

    // Model: per instance, whether transmitting, which sample index is on q, and the latched word.
    logic        m_act [2] = '{1'b0, 1'b0};
    logic        m_err [2] = '{1'b0, 1'b0};
    int          m_t   [2] = '{0, 0};
    logic [23:0] m_w   [2] = '{24'h0, 24'h0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_act[k] = 1'b0;
                m_err[k] = 1'b0;
            end else begin
                m_err[k] = 1'b0;
                if (m_act[k]) begin
                    if (ab[k]) m_act[k] = 1'b0;
                    else if (m_t[k] == total_len(k) - 1) m_act[k] = 1'b0;
                    else m_t[k] = m_t[k] + 1;
                end else if (fv[k] && !ab[k]) begin
                    if (has_illegal(fdata[k])) m_err[k] = 1'b1;
                    else begin
                        m_act[k] = 1'b1;
                        m_t[k]   = 0;
                        m_w[k]   = fdata[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic eq, eb, efd, etx;
            eq  = m_act[k] ? exp_q(m_w[k], m_t[k]) : 1'b0;
            eb  = m_act[k];
            efd = m_act[k] && ((m_t[k] % FLEN) == FLEN - 1);
            etx = m_act[k] && (m_t[k] == total_len(k) - 1);
            chk("q", k, 32'(q[k]), 32'(eq));
            chk("busy", k, 32'(busy[k]), 32'(eb));
            chk("frame_ready", k, 32'(ready[k]), 32'(!eb));
            chk("frame_done", k, 32'(fdone[k]), 32'(efd));
            chk("tx_done", k, 32'(txd[k]), 32'(etx));
            chk("code_err", k, 32'(cerr[k]), 32'(m_err[k]));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic accept(input int k, input logic [23:0] w);
        fdata[k] = w;
        fv[k]    = 1'b1;
        step(1);
        fv[k]    = 1'b0;
    endtask

    logic [23:0] alt;
    int busy_cnt, tx_cnt, tx_pos, fd_cnt, fd_first, fd_last;

    initial begin
        rst_n = 1'b0;
        fv    = '{1'b0, 1'b0};
        ab    = '{1'b0, 1'b0};
        fdata = '{24'h0, 24'h0};
        alt   = '0;
        for (int i = 0; i < TRITS; i++) alt[2*i +: 2] = 2'(i % 3);

        // Literal anchors for the model's waveform rules
        chk("model_zero_s0", 0, 32'(exp_q(24'h0, 0)), 32'd1);
        chk("model_zero_s4", 0, 32'(exp_q(24'h0, 4)), 32'd0);
        chk("model_one_s11", 0, 32'(exp_q(24'h1, 11)), 32'd1);
        chk("model_one_s12", 0, 32'(exp_q(24'h1, 12)), 32'd0);
        chk("model_float_s20", 0, 32'(exp_q(24'h2, 20)), 32'd1);
        chk("model_float_s28", 0, 32'(exp_q(24'h2, 28)), 32'd0);
        chk("model_trit1_s5", 0, 32'(exp_q(24'h1, 37)), 32'd0);
        chk("model_sync_s3", 0, 32'(exp_q(24'h0, 387)), 32'd1);
        chk("model_sync_s4", 0, 32'(exp_q(24'h0, 388)), 32'd0);

        step(3);
        rst_n = 1'b1;
        step(2);
        chk("reset_q", 0, 32'(q[0]), 32'd0);
        chk("reset_ready", 0, 32'(ready[0]), 32'd1);
        chk("reset_busy", 1, 32'(busy[1]), 32'd0);

        // All-zero word on the single-frame instance
        accept(0, 24'h0);
        busy_cnt = 0; tx_cnt = 0; tx_pos = -1; fd_pos_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (busy[0]) busy_cnt++;
            if (txd[0]) begin tx_cnt++; tx_pos = i; end
            if (fdone[0]) begin fd_cnt++; fd_last = i; end
        end
        chk("t1_busy_cycles", 0, 32'(busy_cnt), 32'd512);
        chk("t1_tx_pos", 0, 32'(tx_pos), 32'd511);
        chk("t1_tx_cnt", 0, 32'(tx_cnt), 32'd1);
        chk("t1_fd_pos", 0, 32'(fd_last), 32'd511);

        // Mixed codes; input changes after accept must be ignored
        accept(0, alt);
        fdata[0] = 24'hFFFFFF;
        step(520);

        // Four frames, frame_valid held during busy
        fdata[1] = ~alt & 24'h555555;
        fv[1] = 1'b1;
        step(1);
        tx_cnt = 0; tx_pos = -1; fd_pos_reset();
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (i == 1900) fv[1] = 1'b0;
            if (txd[1]) begin tx_cnt++; tx_pos = i; end
            if (fdone[1]) begin
                if (fd_cnt == 0) fd_first = i;
                fd_cnt++;
                fd_last = i;
            end
        end
        chk("t3_fd_cnt", 1, 32'(fd_cnt), 32'd4);
        chk("t3_fd_first", 1, 32'(fd_first), 32'd511);
        chk("t3_fd_last", 1, 32'(fd_last), 32'd2047);
        chk("t3_tx_cnt", 1, 32'(tx_cnt), 32'd1);
        chk("t3_tx_pos", 1, 32'(tx_pos), 32'd2047);

        // Trit 5 illegal
        accept(0, 24'h000C00);
        @(negedge clk);
        chk("t4_code_err", 0, 32'(cerr[0]), 32'd1);
        chk("t4_busy", 0, 32'(busy[0]), 32'd0);
        @(negedge clk);
        chk("t4_code_err_end", 0, 32'(cerr[0]), 32'd0);
        chk("t4_q", 0, 32'(q[0]), 32'd0);

        // Abort in the second frame, then restart at once
        accept(1, alt);
        step(FLEN + 199);
        ab[1] = 1'b1;
        step(1);
        ab[1] = 1'b0;
        @(negedge clk);
        chk("t5_busy", 1, 32'(busy[1]), 32'd0);
        chk("t5_q", 1, 32'(q[1]), 32'd0);
        accept(1, 24'h189246);
        step(4 * FLEN + 10);

        // Asynchronous reset mid-trit
        accept(0, alt);
        step(100);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_q", 0, 32'(q[0]), 32'd0);
        chk("t6_busy", 0, 32'(busy[0]), 32'd0);
        chk("t6_ready", 0, 32'(ready[0]), 32'd1);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("t6_ready_after", 0, 32'(ready[0]), 32'd1);
        accept(0, 24'h6A5291);
        step(FLEN + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic fd_pos_reset();
        fd_cnt   = 0;
        fd_first = -1;
        fd_last  = -1;
    endtask

endmodule
